// File: rtl/crypto_seq_ctrl_pkg.sv
// Shared definitions for the scalar-crypto sequencer: FSM encoding, op-bit
// positions inside the decoded crypto_instruction bundle and default timing.
package crypto_seq_ctrl_pkg;

  localparam int OP_W    = 18;
  localparam int BS_W    = 2;
  localparam int INSTR_W = OP_W + BS_W;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  // Byte-select field position in crypto_instruction
  localparam int BS_LSB = 18;
  localparam int BS_MSB = 19;

  // One-hot op bit positions in crypto_instruction[17:0]
  localparam int OP_SAES32_ENCS   = 17;
  localparam int OP_SAES32_ENCSM  = 16;
  localparam int OP_SAES32_DECS   = 15;
  localparam int OP_SAES32_DECSM  = 14;
  localparam int OP_SSHA256_SIG0  = 13;
  localparam int OP_SSHA256_SIG1  = 12;
  localparam int OP_SSHA256_SUM0  = 11;
  localparam int OP_SSHA256_SUM1  = 10;
  localparam int OP_SSHA512_SIG0H = 9;
  localparam int OP_SSHA512_SIG0L = 8;
  localparam int OP_SSHA512_SIG1H = 7;
  localparam int OP_SSHA512_SIG1L = 6;
  localparam int OP_SSHA512_SUM0R = 5;
  localparam int OP_SSHA512_SUM1R = 4;
  localparam int OP_SSM3_P0       = 3;
  localparam int OP_SSM3_P1       = 2;
  localparam int OP_SSM4_KS       = 1;
  localparam int OP_SSM4_ED       = 0;

  // Decoded crypto op bundle as delivered by the control unit
  typedef struct packed {
    logic [BS_W-1:0] bs;
    logic [OP_W-1:0] op;
  } crypto_instr_t;

endpackage

// File: rtl/crypto_seq_ctrl_if.sv
// Bundle of the decode/register-file side, the crypto-unit side and the
// write-back side of the sequencer. The slave modport is the sequencer
// itself; the master modport is whatever surrounds it (core + crypto unit).
interface crypto_seq_ctrl_if;
  import crypto_seq_ctrl_pkg::*;

  // decode / register file
  logic               instr_valid;
  logic               is_scalar_crypto;
  logic [INSTR_W-1:0] crypto_instruction;
  logic [4:0]         rd_in;
  logic [31:0]        rs1_val;
  logic [31:0]        rs2_val;
  logic               flush;

  // crypto unit
  logic               cu_start;
  logic [OP_W-1:0]    cu_op;
  logic [BS_W-1:0]    cu_bs;
  logic [31:0]        cu_a;
  logic [31:0]        cu_b;
  logic               cu_done;
  logic [31:0]        cu_result;

  // core control / write-back
  logic               crypto_stall;
  logic               wb_en;
  logic [4:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               crypto_err;

  modport slave (
    input  instr_valid, is_scalar_crypto, crypto_instruction, rd_in,
           rs1_val, rs2_val, flush, cu_done, cu_result,
    output cu_start, cu_op, cu_bs, cu_a, cu_b,
           crypto_stall, wb_en, wb_rd, wb_data, crypto_err
  );

  modport master (
    output instr_valid, is_scalar_crypto, crypto_instruction, rd_in,
           rs1_val, rs2_val, flush, cu_done, cu_result,
    input  cu_start, cu_op, cu_bs, cu_a, cu_b,
           crypto_stall, wb_en, wb_rd, wb_data, crypto_err
  );

endinterface

// File: rtl/crypto_seq_ctrl_onehot_chk.sv
// Combinational exactly-one-bit-set detector for the crypto op field.
// Also used by the crypto unit to qualify its own op input.
module onehot_chk
  import crypto_seq_ctrl_pkg::*;
#(
  parameter int W = OP_W
) (
  input  logic [W-1:0] vec_i,
  output logic         onehot_o
);

  // Non-zero and clearing the lowest set bit leaves nothing behind
  always_comb begin
    onehot_o = (vec_i != {W{1'b0}}) &&
               ((vec_i & (vec_i - {{(W-1){1'b0}}, 1'b1})) == {W{1'b0}});
  end

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Sequencer for the multi-cycle scalar-crypto unit: accepts one decoded op,
// launches the unit, stalls the core until the result returns (or the op is
// flushed / times out) and issues a single register-file write.
module crypto_seq_ctrl
  import crypto_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  crypto_seq_ctrl_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [OP_W-1:0]  op_q,    op_d;
  logic [BS_W-1:0]  bs_q,    bs_d;
  logic [31:0]      a_q,     a_d;
  logic [31:0]      b_q,     b_d;
  logic [4:0]       rd_q,    rd_d;
  logic [31:0]      wdat_q,  wdat_d;
  logic             start_q, start_d;
  logic             wben_q,  wben_d;
  logic             err_q,   err_d;

  logic             accept_s;
  logic             op_legal_s;
  logic             timeout_s;
  logic             stall_s;

  onehot_chk #(.W(OP_W)) u_onehot_chk (
    .vec_i    (bus.crypto_instruction[OP_W-1:0]),
    .onehot_o (op_legal_s)
  );

  // Accept qualification and timeout detection
  always_comb begin
    accept_s  = bus.instr_valid & bus.is_scalar_crypto & ~bus.flush;
    timeout_s = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and registered-output logic of the sequencing FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    bs_d    = bs_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    wdat_d  = wdat_q;
    start_d = 1'b0;
    wben_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_legal_s) begin
            op_d    = bus.crypto_instruction[OP_W-1:0];
            bs_d    = bus.crypto_instruction[BS_MSB:BS_LSB];
            a_d     = bus.rs1_val;
            b_d     = bus.rs2_val;
            rd_d    = bus.rd_in;
            start_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            // malformed bundle: report and drop, never launch the unit
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // cu_start is high this cycle; cu_done cannot legally arrive yet
        cnt_d = {CNT_W{1'b0}};
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bus.flush) begin
          // a result arriving with the flush belongs to a killed op
          state_d = ST_IDLE;
        end else if (bus.cu_done) begin
          // result wins over a coincident timeout
          wdat_d  = bus.cu_result;
          wben_d  = (rd_q != 5'd0);
          state_d = ST_WB;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WB: begin
        // write is already on wb_en this cycle; flush cannot cancel it
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Core stall: held while the op is in flight, and in the accept cycle
  always_comb begin
    case (state_q)
      ST_IDLE:  stall_s = accept_s;
      ST_ISSUE: stall_s = 1'b1;
      ST_WAIT:  stall_s = 1'b1;
      ST_WB:    stall_s = 1'b0;
      default:  stall_s = 1'b0;
    endcase
  end

  // State, operand and output registers; reset drops any in-flight op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= {OP_W{1'b0}};
      bs_q    <= {BS_W{1'b0}};
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rd_q    <= 5'd0;
      wdat_q  <= 32'd0;
      start_q <= 1'b0;
      wben_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      bs_q    <= bs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      wdat_q  <= wdat_d;
      start_q <= start_d;
      wben_q  <= wben_d;
      err_q   <= err_d;
    end
  end

  assign bus.cu_start     = start_q;
  assign bus.cu_op        = op_q;
  assign bus.cu_bs        = bs_q;
  assign bus.cu_a         = a_q;
  assign bus.cu_b         = b_q;
  assign bus.wb_en        = wben_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = wdat_q;
  assign bus.crypto_err   = err_q;
  assign bus.crypto_stall = stall_s;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl: a table of single-accept vectors plus
// hand-written sequences for completion, timeout, flush, rd=0 and reset.
module tb_crypto_seq_ctrl;
  import crypto_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crypto_seq_ctrl_if bus_if ();

  crypto_seq_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        valid;
    logic        sc;
    logic        flush;
    logic [19:0] instr;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_stall;
    logic        exp_start;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk_op(input logic [1:0] bs, input int idx);
    logic [19:0] v;
    v = 20'd0;
    v[idx] = 1'b1;
    v[19:18] = bs;
    return v;
  endfunction

  function automatic vec_t mk_vec(input logic v, input logic s, input logic f,
                                  input logic [19:0] ins, input logic [4:0] rd,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic es, input logic est, input logic ee);
    vec_t r;
    r.valid = v; r.sc = s; r.flush = f; r.instr = ins; r.rd = rd;
    r.a = a; r.b = b; r.exp_stall = es; r.exp_start = est; r.exp_err = ee;
    return r;
  endfunction

  task automatic idle_inputs();
    bus_if.instr_valid        = 1'b0;
    bus_if.is_scalar_crypto   = 1'b0;
    bus_if.crypto_instruction = 20'd0;
    bus_if.rd_in              = 5'd0;
    bus_if.rs1_val            = 32'd0;
    bus_if.rs2_val            = 32'd0;
    bus_if.flush              = 1'b0;
    bus_if.cu_done            = 1'b0;
    bus_if.cu_result          = 32'd0;
  endtask

  task automatic drive_accept(input logic [19:0] instr, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] b);
    bus_if.instr_valid        = 1'b1;
    bus_if.is_scalar_crypto   = 1'b1;
    bus_if.crypto_instruction = instr;
    bus_if.rd_in              = rd;
    bus_if.rs1_val            = a;
    bus_if.rs2_val            = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cu_start"}, 32'(bus_if.cu_start), 32'd0);
    chk({tag, "_cu_op"},    32'(bus_if.cu_op),    32'd0);
    chk({tag, "_cu_bs"},    32'(bus_if.cu_bs),    32'd0);
    chk({tag, "_cu_a"},     bus_if.cu_a,          32'd0);
    chk({tag, "_cu_b"},     bus_if.cu_b,          32'd0);
    chk({tag, "_wb_en"},    32'(bus_if.wb_en),    32'd0);
    chk({tag, "_wb_rd"},    32'(bus_if.wb_rd),    32'd0);
    chk({tag, "_wb_data"},  bus_if.wb_data,       32'd0);
    chk({tag, "_err"},      32'(bus_if.crypto_err), 32'd0);
    chk({tag, "_stall"},    32'(bus_if.crypto_stall), 32'd0);
  endtask

  // Full op: accept at t0, start at t1, cu_done at t(dly+1), write at t(dly+2)
  task automatic run_op(input string tag, input logic [19:0] instr, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input int dly, input logic [31:0] res);
    @(negedge clk);
    drive_accept(instr, rd, a, b);
    #1;
    chk({tag, "_stall_t0"}, 32'(bus_if.crypto_stall), 32'd1);
    for (int t = 1; t <= dly + 3; t++) begin
      @(negedge clk);
      bus_if.instr_valid = 1'b0;
      bus_if.cu_done     = (t == dly + 1);
      bus_if.cu_result   = (t == dly + 1) ? res : 32'h0BAD_0BAD;
      #1;
      chk({tag, "_stall"}, 32'(bus_if.crypto_stall), 32'(t <= dly + 1));
      chk({tag, "_start"}, 32'(bus_if.cu_start),     32'(t == 1));
      chk({tag, "_wb_en"}, 32'(bus_if.wb_en),        32'((t == dly + 2) && (rd != 5'd0)));
      chk({tag, "_err"},   32'(bus_if.crypto_err),   32'd0);
      if (t == 1) begin
        chk({tag, "_cu_op"}, 32'(bus_if.cu_op), 32'(instr[17:0]));
        chk({tag, "_cu_bs"}, 32'(bus_if.cu_bs), 32'(instr[19:18]));
        chk({tag, "_cu_a"},  bus_if.cu_a, a);
        chk({tag, "_cu_b"},  bus_if.cu_b, b);
      end
      if (t == dly + 2) begin
        chk({tag, "_wb_rd"},   32'(bus_if.wb_rd), 32'(rd));
        chk({tag, "_wb_data"}, bus_if.wb_data,    res);
      end
    end
    bus_if.cu_done = 1'b0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    int wbs;
    int first_t;

    tbl[0] = mk_vec(1'b1, 1'b1, 1'b0, 20'd0,                 5'd1, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1);
    tbl[1] = mk_vec(1'b1, 1'b1, 1'b0, 20'h00018,             5'd2, 32'h3, 32'h4, 1'b1, 1'b0, 1'b1);
    tbl[2] = mk_vec(1'b1, 1'b1, 1'b0, 20'hFFFFF,             5'd3, 32'h5, 32'h6, 1'b1, 1'b0, 1'b1);
    tbl[3] = mk_vec(1'b0, 1'b1, 1'b0, mk_op(2'd1, OP_SSM3_P0), 5'd4, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk_vec(1'b1, 1'b0, 1'b0, mk_op(2'd1, OP_SSM3_P0), 5'd4, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk_vec(1'b1, 1'b1, 1'b1, mk_op(2'd1, OP_SSM3_P0), 5'd4, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk_vec(1'b1, 1'b1, 1'b0, mk_op(2'd2, OP_SSM4_ED), 5'd9, 32'hCAFE_0001, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    tbl[7] = mk_vec(1'b1, 1'b1, 1'b0, mk_op(2'd1, OP_SSHA512_SIG0H), 5'd31, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1, 1'b1, 1'b0);
    tbl[8] = mk_vec(1'b1, 1'b1, 1'b0, 20'h20001,             5'd7, 32'h9, 32'hA, 1'b1, 1'b0, 1'b1);

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table: single accept attempt from IDLE, then back to IDLE
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus_if.instr_valid        = tbl[i].valid;
      bus_if.is_scalar_crypto   = tbl[i].sc;
      bus_if.flush              = tbl[i].flush;
      bus_if.crypto_instruction = tbl[i].instr;
      bus_if.rd_in              = tbl[i].rd;
      bus_if.rs1_val            = tbl[i].a;
      bus_if.rs2_val            = tbl[i].b;
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(bus_if.crypto_stall), 32'(tbl[i].exp_stall));
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("tbl%0d_start", i), 32'(bus_if.cu_start),   32'(tbl[i].exp_start));
      chk($sformatf("tbl%0d_err", i),   32'(bus_if.crypto_err), 32'(tbl[i].exp_err));
      if (tbl[i].exp_start) begin
        chk($sformatf("tbl%0d_cu_op", i), 32'(bus_if.cu_op), 32'(tbl[i].instr[17:0]));
        chk($sformatf("tbl%0d_cu_bs", i), 32'(bus_if.cu_bs), 32'(tbl[i].instr[19:18]));
        chk($sformatf("tbl%0d_cu_a", i),  bus_if.cu_a, tbl[i].a);
        chk($sformatf("tbl%0d_cu_b", i),  bus_if.cu_b, tbl[i].b);
        bus_if.flush = 1'b1;
      end
      @(negedge clk);
      bus_if.flush = 1'b0;
      #1;
      chk($sformatf("tbl%0d_start_after", i), 32'(bus_if.cu_start),     32'd0);
      chk($sformatf("tbl%0d_err_after", i),   32'(bus_if.crypto_err),   32'd0);
      chk($sformatf("tbl%0d_stall_after", i), 32'(bus_if.crypto_stall), 32'd0);
      chk($sformatf("tbl%0d_wb_after", i),    32'(bus_if.wb_en),        32'd0);
    end

    // Legal saes32_encs, result four cycles after the start pulse
    run_op("aes", mk_op(2'd0, OP_SAES32_ENCS), 5'd5, 32'h0011_2233, 32'h4455_6677, 4, 32'hDEAD_BEEF);

    // Timeout: cu_done never comes
    errs = 0; wbs = 0; first_t = -1;
    @(negedge clk);
    drive_accept(mk_op(2'd0, OP_SSHA256_SIG0), 5'd6, 32'h1111_1111, 32'h2222_2222);
    #1;
    chk("to_stall_t0", 32'(bus_if.crypto_stall), 32'd1);
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      bus_if.instr_valid = 1'b0;
      #1;
      if (bus_if.crypto_err) begin
        errs++;
        if (first_t < 0) first_t = t;
      end
      if (bus_if.wb_en) wbs++;
      chk("to_stall", 32'(bus_if.crypto_stall), 32'(t <= 65));
    end
    chk("to_err_count", 32'(errs), 32'd1);
    chk("to_err_cycle", 32'(first_t), 32'd66);
    chk("to_no_wb", 32'(wbs), 32'd0);
    run_op("after_to", mk_op(2'd3, OP_SAES32_DECSM), 5'd12, 32'h0A0B_0C0D, 32'h1020_3040, 1, 32'h5555_AAAA);

    // Flush in the 2nd WAIT cycle together with cu_done
    @(negedge clk);
    drive_accept(mk_op(2'd0, OP_SSM3_P1), 5'd8, 32'h3333_3333, 32'h4444_4444);
    @(negedge clk);
    bus_if.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_if.flush     = 1'b1;
    bus_if.cu_done   = 1'b1;
    bus_if.cu_result = 32'h7777_7777;
    #1;
    chk("fl_stall_flush_cycle", 32'(bus_if.crypto_stall), 32'd1);
    for (int t = 4; t <= 5; t++) begin
      @(negedge clk);
      bus_if.flush   = 1'b0;
      bus_if.cu_done = 1'b0;
      #1;
      chk("fl_stall", 32'(bus_if.crypto_stall), 32'd0);
      chk("fl_wb_en", 32'(bus_if.wb_en),        32'd0);
      chk("fl_err",   32'(bus_if.crypto_err),   32'd0);
      chk("fl_start", 32'(bus_if.cu_start),     32'd0);
    end
    run_op("after_fl", mk_op(2'd2, OP_SSM4_KS), 5'd20, 32'h9999_0000, 32'h0000_9999, 2, 32'hBEEF_CAFE);

    // Destination x0: full sequence, write suppressed
    run_op("rd0", mk_op(2'd1, OP_SSHA256_SUM1), 5'd0, 32'h1357_9BDF, 32'h2468_ACE0, 3, 32'hFACE_FEED);

    // Reset while in WAIT, released with cu_done pulsing
    @(negedge clk);
    drive_accept(mk_op(2'd0, OP_SAES32_ENCSM), 5'd10, 32'hAAAA_0000, 32'h0000_BBBB);
    @(negedge clk);
    bus_if.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    @(negedge clk);
    bus_if.cu_done   = 1'b1;
    bus_if.cu_result = 32'h1234_ABCD;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      bus_if.cu_done = (t == 0);
      #1;
      chk("rst_wb_en", 32'(bus_if.wb_en),        32'd0);
      chk("rst_err",   32'(bus_if.crypto_err),   32'd0);
      chk("rst_stall", 32'(bus_if.crypto_stall), 32'd0);
      chk("rst_start", 32'(bus_if.cu_start),     32'd0);
    end
    bus_if.cu_done = 1'b0;
    run_op("after_rst", mk_op(2'd3, OP_SSHA512_SUM0R), 5'd17, 32'h0F1E_2D3C, 32'h4B5A_6978, 5, 32'h0102_0304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
